// File: rtl/apb_2_lint_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_2_lint_pkg
//  Brief    : Shared types and constants for the APB3-slave to LINT-master
//             bridge (FSM state encoding, full byte-enable, default timeout).
//  Revision : 1.0 - initial release
// ============================================================================
package apb_2_lint_pkg;

  // Bridge FSM: capture setup, wait for grant, wait for response, ack APB
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  // APB3 has no strobes, so every LINT access is a full 32-bit word
  localparam logic [3:0] LINT_BE_FULL = 4'hF;

  // Abort threshold used when the timeout build option is enabled
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/apb_2_lint_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_2_lint_if
//  Brief    : Bundles the APB3 slave port and the LINT master port of the
//             bridge. 'slave' is the bridge view, 'master' the environment
//             view (APB initiator plus LINT target).
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_2_lint_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);

  // APB3 side
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  // LINT side
  logic                  data_req_o;
  logic [ADDR_WIDTH-1:0] data_add_o;
  logic                  data_we_o;
  logic [DATA_WIDTH-1:0] data_wdata_o;
  logic [BE_WIDTH-1:0]   data_be_o;
  logic                  data_gnt_i;
  logic                  data_r_valid_i;
  logic [DATA_WIDTH-1:0] data_r_rdata_i;

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR,
    output data_req_o, data_add_o, data_we_o, data_wdata_o, data_be_o,
    input  data_gnt_i, data_r_valid_i, data_r_rdata_i
  );

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR,
    input  data_req_o, data_add_o, data_we_o, data_wdata_o, data_be_o,
    output data_gnt_i, data_r_valid_i, data_r_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/apb_2_lint.sv
`default_nettype none
// ============================================================================
//  Module   : apb_2_lint
//  Brief    : APB3 slave to LINT master bridge. One outstanding word access;
//             PREADY is held low until the LINT response returns. All
//             outputs are registered.
//  Options  : APB_2_LINT_TIMEOUT_EN - abort a transfer after TIMEOUT_CYCLES
//             cycles in REQ/RESP with PSLVERR, and swallow the late response.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_2_lint
  import apb_2_lint_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  apb_2_lint_if.slave      bus
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] add_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;

  logic                  w_timeout;  // abort threshold reached this cycle
  logic                  w_rvalid;   // response that belongs to this transfer
  logic                  w_unused;

`ifdef APB_2_LINT_TIMEOUT_EN
  localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_to_max  = c_cnt_w'(TIMEOUT_CYCLES);

  logic [c_cnt_w-1:0] cnt_q;
  logic               drop_rvalid_q;

  // Fires on the edge that ends the TIMEOUT_CYCLES-th cycle spent in REQ/RESP
  assign w_timeout = (cnt_q >= c_to_last);
  // A response owed to an aborted transfer is consumed here, not forwarded
  assign w_rvalid  = bus.data_r_valid_i && !drop_rvalid_q;

  // Cycle counter: cleared while idle, counts REQ/RESP cycles, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == REQ || state_q == RESP) && cnt_q != c_to_max) begin
      cnt_q <= cnt_q + c_cnt_w'(1);
    end
  end

  // Remember that a granted request was abandoned so its late rvalid is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_rvalid_q <= 1'b0;
    end else if (state_q == RESP && !w_rvalid && w_timeout) begin
      drop_rvalid_q <= 1'b1;
    end else if (bus.data_r_valid_i) begin
      drop_rvalid_q <= 1'b0;
    end
  end

  assign w_unused = ^bus.PADDR[1:0];
`else
  assign w_timeout = 1'b0;
  assign w_rvalid  = bus.data_r_valid_i;
  assign w_unused  = ^{bus.PADDR[1:0], (TIMEOUT_CYCLES != 0)};
`endif

  // Bridge FSM with all APB and LINT outputs registered in the same block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      req_q     <= 1'b0;
      add_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Launch the LINT request straight from the APB setup phase
          if (bus.PSEL && !bus.PENABLE) begin
            add_q   <= {bus.PADDR[ADDR_WIDTH-1:2], 2'b00};
            we_q    <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            be_q    <= LINT_BE_FULL;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Progress beats the timeout when both land on the same edge
          if (bus.data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= RESP;
          end else if (w_timeout) begin
            req_q     <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        RESP: begin
          if (w_rvalid) begin
            if (!we_q) begin
              prdata_q <= bus.data_r_rdata_i;
            end
            pready_q <= 1'b1;
            state_q  <= DONE;
          end else if (w_timeout) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // PREADY was high for exactly this cycle; APB access ends here
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.PRDATA       = prdata_q;
  assign bus.PREADY       = pready_q;
  assign bus.PSLVERR      = pslverr_q;
  assign bus.data_req_o   = req_q;
  assign bus.data_add_o   = add_q;
  assign bus.data_we_o    = we_q;
  assign bus.data_wdata_o = wdata_q;
  assign bus.data_be_o    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_2_lint.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_2_lint
//  Brief    : Self-checking bench for apb_2_lint. Drives APB transfers and
//             plays the LINT target; expected APB completions are queued
//             when a transfer is launched and checked when PREADY appears.
//  Options  : APB_2_LINT_TIMEOUT_EN - also exercises the abort path with a
//             threshold of 8 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_2_lint;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef APB_2_LINT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  apb_2_lint_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  apb_2_lint #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BE_WIDTH      (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prdata;
    logic        pslverr;
    int          ready_cycle;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Observations of the most recent transfer
  logic        o_req0, o_we, o_pslverr, o_req_at_ready, o_ready_after, o_req_after, o_slverr_after;
  logic [31:0] o_add, o_wdata, o_prdata;
  logic [3:0]  o_be;
  bit          o_stable;
  int          o_ready_cycle;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer with a scripted LINT target. Cycle 0 is the setup phase.
  // gnt_wait < 0 withholds the grant; rv_wait < 0 withholds the response.
  // stale_first injects a foreign rvalid in the first RESP cycle.
  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic write, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rsp_data, input bit stale_first);
    bit granted = 0;
    bit rv_done = 0;
    int gwait   = 0;
    int rcyc    = 0;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PWRITE  = write;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.data_gnt_i     = 1'b0;
    bus.data_r_valid_i = 1'b0;
    tick();
    o_req0        = bus.data_req_o;
    o_add         = bus.data_add_o;
    o_we          = bus.data_we_o;
    o_wdata       = bus.data_wdata_o;
    o_be          = bus.data_be_o;
    o_stable      = 1;
    o_ready_cycle = -1;
    o_ready_after = 1'bx;
    bus.PENABLE   = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      bus.data_gnt_i     = 1'b0;
      bus.data_r_valid_i = 1'b0;
      bus.data_r_rdata_i = '0;
      if (bus.PREADY === 1'b1) begin
        o_ready_cycle  = c;
        o_prdata       = bus.PRDATA;
        o_pslverr      = bus.PSLVERR;
        o_req_at_ready = bus.data_req_o;
        break;
      end
      if (!granted) begin
        if (bus.data_req_o !== 1'b1 || bus.data_add_o !== o_add || bus.data_we_o !== o_we ||
            bus.data_wdata_o !== o_wdata || bus.data_be_o !== o_be)
          o_stable = 0;
        if (gnt_wait >= 0 && gwait == gnt_wait) begin
          bus.data_gnt_i = 1'b1;
          granted = 1;
        end else begin
          gwait++;
        end
      end else begin
        if (stale_first && rcyc == 0) begin
          bus.data_r_valid_i = 1'b1;
          bus.data_r_rdata_i = 32'hDEAD_BEEF;
        end else if (!rv_done && rv_wait >= 0 && rcyc == rv_wait + (stale_first ? 1 : 0)) begin
          bus.data_r_valid_i = 1'b1;
          bus.data_r_rdata_i = rsp_data;
          rv_done = 1;
        end
        rcyc++;
      end
      tick();
    end
    bus.data_gnt_i     = 1'b0;
    bus.data_r_valid_i = 1'b0;
    if (o_ready_cycle >= 0) begin
      tick();
      o_ready_after  = bus.PREADY;
      o_req_after    = bus.data_req_o;
      o_slverr_after = bus.PSLVERR;
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({bus.PRDATA, bus.PREADY, bus.PSLVERR, bus.data_req_o, bus.data_add_o,
         bus.data_we_o, bus.data_wdata_o, bus.data_be_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got prdata=%h pready=%b slverr=%b req=%b add=%h we=%b wdata=%h be=%h want all zero",
               bus.PRDATA, bus.PREADY, bus.PSLVERR, bus.data_req_o, bus.data_add_o,
               bus.data_we_o, bus.data_wdata_o, bus.data_be_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_immediate();
    sb_q.push_back('{32'hCAFE_F00D, 1'b0, 3});
    do_xfer(32'h1000_0004, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D, 0);
    vectors++;
    if ({o_req0, o_add, o_we, o_be} !== {1'b1, 32'h1000_0004, 1'b0, 4'hF}) begin
      miscompares++;
      $display("FAIL rd_lint_fields: got req=%b add=%h we=%b be=%h want 1 10000004 0 f", o_req0, o_add, o_we, o_be);
    end
    e = sb_q.pop_front();
    vectors++;
    if (o_ready_cycle !== e.ready_cycle) begin
      miscompares++;
      $display("FAIL rd_ready_cycle: got %0d want %0d", o_ready_cycle, e.ready_cycle);
    end
    vectors++;
    if ({o_prdata, o_pslverr} !== {e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL rd_data: got prdata=%h slverr=%b want %h %b", o_prdata, o_pslverr, e.prdata, e.pslverr);
    end
    vectors++;
    if (o_ready_after !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_ready_pulse: got pready after DONE=%b want 0", o_ready_after);
    end
  endtask

  task automatic test_write_delayed_gnt();
    sb_q.push_back('{32'hCAFE_F00D, 1'b0, 5 + 1 + 3});
    do_xfer(32'h1000_0013, 32'h1234_5678, 1'b1, 5, 1, 32'h5555_AAAA, 0);
    vectors++;
    if ({o_add, o_we, o_wdata, o_be} !== {32'h1000_0010, 1'b1, 32'h1234_5678, 4'hF}) begin
      miscompares++;
      $display("FAIL wr_lint_fields: got add=%h we=%b wdata=%h be=%h want 10000010 1 12345678 f", o_add, o_we, o_wdata, o_be);
    end
    vectors++;
    if (o_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_req_stable: got stable=%b want 1", o_stable);
    end
    e = sb_q.pop_front();
    vectors++;
    if (o_ready_cycle !== e.ready_cycle) begin
      miscompares++;
      $display("FAIL wr_ready_cycle: got %0d want %0d", o_ready_cycle, e.ready_cycle);
    end
    vectors++;
    if ({o_prdata, o_pslverr} !== {e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL wr_prdata_hold: got prdata=%h slverr=%b want %h %b", o_prdata, o_pslverr, e.prdata, e.pslverr);
    end
  endtask

  task automatic test_back_to_back();
    sb_q.push_back('{32'h0BAD_C0DE, 1'b0, 3});
    do_xfer(32'h2000_0008, 32'h0, 1'b0, 0, 0, 32'h0BAD_C0DE, 0);
    e = sb_q.pop_front();
    vectors++;
    if ({o_ready_cycle, o_prdata, o_pslverr} !== {e.ready_cycle, e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL b2b_read: got cyc=%0d prdata=%h slverr=%b want %0d %h %b",
               o_ready_cycle, o_prdata, o_pslverr, e.ready_cycle, e.prdata, e.pslverr);
    end
    vectors++;
    if (o_req_after !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_req_gap: got req in IDLE=%b want 0", o_req_after);
    end
    sb_q.push_back('{32'h0BAD_C0DE, 1'b0, 1 + 1 + 3});
    do_xfer(32'h2000_000C, 32'h7777_1111, 1'b1, 1, 1, 32'hFFFF_FFFF, 0);
    vectors++;
    if ({o_req0, o_add, o_we, o_wdata} !== {1'b1, 32'h2000_000C, 1'b1, 32'h7777_1111}) begin
      miscompares++;
      $display("FAIL b2b_write_fields: got req=%b add=%h we=%b wdata=%h want 1 2000000c 1 77771111",
               o_req0, o_add, o_we, o_wdata);
    end
    e = sb_q.pop_front();
    vectors++;
    if ({o_ready_cycle, o_prdata, o_pslverr} !== {e.ready_cycle, e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL b2b_write: got cyc=%0d prdata=%h slverr=%b want %0d %h %b",
               o_ready_cycle, o_prdata, o_pslverr, e.ready_cycle, e.prdata, e.pslverr);
    end
  endtask

  task automatic test_reset_mid();
    bit ready_seen = 0;
    bus.PADDR   = 32'h3000_0000;
    bus.PWRITE  = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    tick();
    bus.PENABLE    = 1'b1;
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.PRDATA, bus.PREADY, bus.PSLVERR, bus.data_req_o, bus.data_add_o,
         bus.data_we_o, bus.data_wdata_o, bus.data_be_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got prdata=%h pready=%b req=%b add=%h be=%h want all zero",
               bus.PRDATA, bus.PREADY, bus.data_req_o, bus.data_add_o, bus.data_be_o);
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.data_r_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0) ready_seen = 1;
      tick();
    end
    vectors++;
    if (ready_seen) begin
      miscompares++;
      $display("FAIL rst_mid_stale_rvalid: got pready/prdata activity=1 want 0");
    end
    sb_q.push_back('{32'h1357_9BDF, 1'b0, 3});
    do_xfer(32'h3000_0004, 32'h0, 1'b0, 0, 0, 32'h1357_9BDF, 0);
    e = sb_q.pop_front();
    vectors++;
    if ({o_ready_cycle, o_prdata, o_pslverr} !== {e.ready_cycle, e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL rst_mid_next_read: got cyc=%0d prdata=%h slverr=%b want %0d %h %b",
               o_ready_cycle, o_prdata, o_pslverr, e.ready_cycle, e.prdata, e.pslverr);
    end
  endtask

`ifdef APB_2_LINT_TIMEOUT_EN
  task automatic test_timeout();
    sb_q.push_back('{32'h1357_9BDF, 1'b1, TO + 1});
    do_xfer(32'h4000_0000, 32'h0, 1'b0, -1, 0, 32'h0, 0);
    e = sb_q.pop_front();
    vectors++;
    if ({o_ready_cycle, o_prdata, o_pslverr} !== {e.ready_cycle, e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL to_req_abort: got cyc=%0d prdata=%h slverr=%b want %0d %h %b",
               o_ready_cycle, o_prdata, o_pslverr, e.ready_cycle, e.prdata, e.pslverr);
    end
    vectors++;
    if ({o_req_at_ready, o_ready_after, o_slverr_after} !== 3'b000) begin
      miscompares++;
      $display("FAIL to_req_release: got req=%b pready_after=%b slverr_after=%b want 0 0 0",
               o_req_at_ready, o_ready_after, o_slverr_after);
    end
  endtask

  task automatic test_late_rvalid();
    sb_q.push_back('{32'h1357_9BDF, 1'b1, TO + 1});
    do_xfer(32'h4000_0010, 32'h0, 1'b0, 0, -1, 32'h0, 0);
    e = sb_q.pop_front();
    vectors++;
    if ({o_ready_cycle, o_prdata, o_pslverr} !== {e.ready_cycle, e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL to_resp_abort: got cyc=%0d prdata=%h slverr=%b want %0d %h %b",
               o_ready_cycle, o_prdata, o_pslverr, e.ready_cycle, e.prdata, e.pslverr);
    end
    sb_q.push_back('{32'h0000_00A5, 1'b0, 0 + 0 + 3 + 1});
    do_xfer(32'h4000_0014, 32'h0, 1'b0, 0, 0, 32'h0000_00A5, 1);
    e = sb_q.pop_front();
    vectors++;
    if ({o_ready_cycle, o_prdata, o_pslverr} !== {e.ready_cycle, e.prdata, e.pslverr}) begin
      miscompares++;
      $display("FAIL late_rvalid_drop: got cyc=%0d prdata=%h slverr=%b want %0d %h %b",
               o_ready_cycle, o_prdata, o_pslverr, e.ready_cycle, e.prdata, e.pslverr);
    end
  endtask
`endif

  initial begin
    bus.PADDR          = '0;
    bus.PWDATA         = '0;
    bus.PWRITE         = 1'b0;
    bus.PSEL           = 1'b0;
    bus.PENABLE        = 1'b0;
    bus.data_gnt_i     = 1'b0;
    bus.data_r_valid_i = 1'b0;
    bus.data_r_rdata_i = '0;
    test_reset();
    test_read_immediate();
    test_write_delayed_gnt();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_2_LINT_TIMEOUT_EN
    test_timeout();
    test_late_rvalid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
